// File: rtl/program_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// program_sequencer_pkg
// Shared definitions for the program sequencer and its return stack:
//   - action_e  : the single action taken in a cycle, listed in priority order
//                 (CLEAR highest, INC lowest; NONE when nothing is requested)
//   - sp_width  : width needed to hold a stack occupancy of 0..DEPTH
//   - idx_width : width needed to address DEPTH stack entries
// ---------------------------------------------------------------------------
package program_sequencer_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        CLEAR = 3'd1,
        RET   = 3'd2,
        CALL  = 3'd3,
        LOAD  = 3'd4,
        COND  = 3'd5,
        INC   = 3'd6
    } action_e;

    // Occupancy counter must represent the full state (DEPTH), hence DEPTH+1 values.
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A single-entry stack still needs a one-bit index.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/program_sequencer_return_stack.sv
// ---------------------------------------------------------------------------
// pc_return_stack
// DEPTH x ADDR_W return-address stack with registered occupancy and sticky
// overflow/underflow flags.
// Ports:
//   clock, reset_n   : clock and asynchronous active-low reset
//   clear_i          : synchronous clear of occupancy and flags
//   push_i, pop_i    : push request (wins over pop if both are given)
//   push_data_i      : address written on a successful push
//   pop_data_o       : current top entry (zero when empty)
//   full_o, empty_o  : occupancy status
//   sp_o             : occupancy, 0..DEPTH
//   ovf_o, unf_o     : sticky push-when-full / pop-when-empty flags
// ---------------------------------------------------------------------------
module pc_return_stack
    import program_sequencer_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [ADDR_W-1:0]            push_data_i,
    output logic [ADDR_W-1:0]            pop_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [sp_width(DEPTH)-1:0]   sp_o,
    output logic                         ovf_o,
    output logic                         unf_o
);

    localparam int SP_W  = sp_width(DEPTH);
    localparam int IDX_W = idx_width(DEPTH);
    localparam logic [SP_W-1:0] DEPTH_SP = SP_W'(DEPTH);
    localparam logic [SP_W-1:0] ONE_SP   = SP_W'(1'b1);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              full_s, empty_s, do_push_s;
    logic [SP_W-1:0]   top_s;
    logic [IDX_W-1:0]  wr_idx_s, rd_idx_s;

    assign full_s    = (sp_q == DEPTH_SP);
    assign empty_s   = (sp_q == {SP_W{1'b0}});
    assign top_s     = sp_q - ONE_SP;
    assign wr_idx_s  = sp_q[IDX_W-1:0];
    assign rd_idx_s  = top_s[IDX_W-1:0];
    // A push request overrides a pop request, and clear overrides both.
    assign do_push_s = push_i & ~full_s & ~clear_i;

    // Top-of-stack read; entries above the occupancy are never exposed.
    always_comb begin
        pop_data_o = {ADDR_W{1'b0}};
        if (!empty_s) begin
            pop_data_o = mem_q[rd_idx_s];
        end else begin
            pop_data_o = {ADDR_W{1'b0}};
        end
    end

    // Next occupancy and sticky flag update.
    always_comb begin
        sp_d  = sp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clear_i) begin
            sp_d  = {SP_W{1'b0}};
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (push_i) begin
            if (full_s) begin
                ovf_d = 1'b1;
            end else begin
                sp_d = sp_q + ONE_SP;
            end
        end else if (pop_i) begin
            if (empty_s) begin
                unf_d = 1'b1;
            end else begin
                sp_d = top_s;
            end
        end else begin
            sp_d = sp_q;
        end
    end

    // Occupancy and flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp_q  <= {SP_W{1'b0}};
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage; contents are only meaningful below the occupancy.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_q[wr_idx_s] <= push_data_i;
        end
    end

    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign sp_o    = sp_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule

// File: rtl/program_sequencer.sv
// ---------------------------------------------------------------------------
// program_sequencer
// Program counter with increment, unconditional/conditional load from a
// shared bus, call/return through a return stack, and a tri-state bus driver.
// One action per cycle, priority clear > ret > call > c_in > c_cond > enable.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   bus            : shared bus; PC driven (zero-extended) while c_out=1
//   enable         : increment PC
//   c_in           : load PC from bus[ADDR_W-1:0]
//   c_cond, flag   : load PC from bus only when flag=1, else hold
//   call, ret      : push PC+1 and jump / pop into PC
//   c_out          : drive PC onto bus; also makes any bus load reload PC
//   clear          : synchronous clear of PC, stack occupancy and flags
//   led            : registered PC
//   sp, ovf, unf   : stack occupancy and sticky overflow/underflow flags
// ---------------------------------------------------------------------------
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int BUS_W  = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    inout  wire  [BUS_W-1:0]            bus,
    input  logic                        enable,
    input  logic                        c_in,
    input  logic                        c_cond,
    input  logic                        flag,
    input  logic                        call,
    input  logic                        ret,
    input  logic                        c_out,
    input  logic                        clear,
    output logic [ADDR_W-1:0]           led,
    output logic [sp_width(DEPTH)-1:0]  sp,
    output logic                        ovf,
    output logic                        unf
);

    action_e            action_s;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_inc_s;
    logic [ADDR_W-1:0]  load_val_s;
    logic [ADDR_W-1:0]  pop_data_s;
    logic               full_s, empty_s;
    logic [BUS_W-1:0]   bus_drv_s;

    // Priority decode: exactly one action wins each cycle.
    always_comb begin
        action_s = NONE;
        if (clear) begin
            action_s = CLEAR;
        end else if (ret) begin
            action_s = RET;
        end else if (call) begin
            action_s = CALL;
        end else if (c_in) begin
            action_s = LOAD;
        end else if (c_cond) begin
            action_s = COND;
        end else if (enable) begin
            action_s = INC;
        end else begin
            action_s = NONE;
        end
    end

    assign pc_inc_s = pc_q + ADDR_W'(1'b1);

    // While we drive the bus ourselves the loaded value is our own PC, so a
    // load in that cycle leaves the PC unchanged regardless of other drivers.
    always_comb begin
        load_val_s = bus[ADDR_W-1:0];
        if (c_out) begin
            load_val_s = pc_q;
        end else begin
            load_val_s = bus[ADDR_W-1:0];
        end
    end

    // Next program counter for the winning action.
    always_comb begin
        pc_d = pc_q;
        case (action_s)
            CLEAR:   pc_d = {ADDR_W{1'b0}};
            RET:     pc_d = empty_s ? pc_q : pop_data_s;
            CALL:    pc_d = full_s  ? pc_q : load_val_s;
            LOAD:    pc_d = load_val_s;
            COND:    pc_d = flag ? load_val_s : pc_q;
            INC:     pc_d = pc_inc_s;
            default: pc_d = pc_q;
        endcase
    end

    // Program counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= {ADDR_W{1'b0}};
        end else begin
            pc_q <= pc_d;
        end
    end

    pc_return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_stack (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear_i     (action_s == CLEAR),
        .push_i      (action_s == CALL),
        .pop_i       (action_s == RET),
        .push_data_i (pc_inc_s),
        .pop_data_o  (pop_data_s),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .sp_o        (sp),
        .ovf_o       (ovf),
        .unf_o       (unf)
    );

    // Zero-extended PC for the bus driver; works for ADDR_W == BUS_W too.
    always_comb begin
        bus_drv_s = {BUS_W{1'b0}};
        bus_drv_s[ADDR_W-1:0] = pc_q;
    end

    assign bus = c_out ? bus_drv_s : {BUS_W{1'bz}};
    assign led = pc_q;

endmodule

// File: tb/tb_program_sequencer.sv
// ---------------------------------------------------------------------------
// tb_program_sequencer
// Directed test of program_sequencer (BUS_W=8, ADDR_W=4, DEPTH=4). A
// behavioural model (integer PC, queue as return stack) is stepped at every
// rising edge; a compare process checks led/sp/ovf/unf/bus against it after
// each edge. Literal expectations pin key points of each scenario.
// ---------------------------------------------------------------------------
module tb_program_sequencer;

    localparam int BUS_W  = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable, c_in, c_cond, flag, call, ret, c_out, clear;
    logic [3:0] led;
    logic [2:0] sp;
    logic       ovf, unf;
    wire  [7:0] bus;
    logic [7:0] tb_bus;
    logic       tb_drive;

    assign bus = tb_drive ? tb_bus : 8'hzz;

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 1'b0;

    // model state
    int m_pc;
    int m_stk[$];
    bit m_ovf, m_unf;

    always #5 clock = ~clock;

    program_sequencer #(.BUS_W(BUS_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .enable  (enable),
        .c_in    (c_in),
        .c_cond  (c_cond),
        .flag    (flag),
        .call    (call),
        .ret     (ret),
        .c_out   (c_out),
        .clear   (clear),
        .led     (led),
        .sp      (sp),
        .ovf     (ovf),
        .unf     (unf)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One cycle of the sequencer's rules, applied to the inputs at the edge.
    task automatic model_step();
        int target;
        target = c_out ? m_pc : int'(tb_bus) % 16;
        if (clear) begin
            model_reset();
        end else if (ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else m_unf = 1'b1;
        end else if (call) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back((m_pc + 1) % 16);
                m_pc = target;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (c_in) begin
            m_pc = target;
        end else if (c_cond) begin
            if (flag) m_pc = target;
        end else if (enable) begin
            m_pc = (m_pc + 1) % 16;
        end
    endtask

    // Compare DUT against model shortly after every rising edge.
    always @(posedge clock) begin
        #2;
        if (chk_en) begin
            chk("cmp_led", int'(led), m_pc);
            chk("cmp_sp",  int'(sp),  m_stk.size());
            chk("cmp_ovf", int'(ovf), int'(m_ovf));
            chk("cmp_unf", int'(unf), int'(m_unf));
            if (c_out) chk("cmp_bus_drv", int'(bus), m_pc);
            else if (tb_drive) chk("cmp_bus_free", int'(bus), int'(tb_bus));
        end
    end

    task automatic idle();
        enable = 1'b0; c_in = 1'b0; c_cond = 1'b0; flag = 1'b0;
        call = 1'b0; ret = 1'b0; c_out = 1'b0; clear = 1'b0;
        tb_drive = 1'b0; tb_bus = 8'h00;
    endtask

    // Inputs are set at a falling edge; apply them across one rising edge.
    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
        idle();
    endtask

    task automatic drive_bus(input logic [7:0] v);
        tb_bus = v;
        tb_drive = 1'b1;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        model_reset();
        #2;
        chk("rst_led", int'(led), 0);
        chk("rst_sp",  int'(sp),  0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_unf", int'(unf), 0);
        @(negedge clock);
        reset_n = 1'b1;
        chk_en = 1'b1;

        // Increment with wrap: 1..15, 0, 1
        for (int i = 1; i <= 17; i++) begin
            enable = 1'b1;
            step();
            chk("inc_led", int'(led), i % 16);
        end
        chk("inc_ovf", int'(ovf), 0);
        chk("inc_unf", int'(unf), 0);

        // c_in ignores upper bus bits; c_out drives bus; released otherwise
        drive_bus(8'h05); c_in = 1'b1; step();
        chk("cin_led5", int'(led), 5);
        drive_bus(8'hA7); c_in = 1'b1; step();
        chk("cin_led7", int'(led), 7);
        c_out = 1'b1;
        #1 chk("cout_bus", int'(bus), 8'h07);
        step();
        drive_bus(8'h5A);
        #1 chk("bus_released", int'(bus), 8'h5A);
        step();

        // Conditional jump; flag=0 holds even with enable
        drive_bus(8'h03); c_in = 1'b1; step();
        drive_bus(8'h09); c_cond = 1'b1; flag = 1'b0; enable = 1'b1; step();
        chk("cond_f0", int'(led), 3);
        drive_bus(8'h09); c_cond = 1'b1; flag = 1'b1; step();
        chk("cond_f1", int'(led), 9);

        // Five calls from PC=2, fifth overflows
        drive_bus(8'h02); c_in = 1'b1; step();
        for (int i = 0; i < 5; i++) begin
            drive_bus(8'(4 + 2 * i)); call = 1'b1; step();
        end
        chk("call_sp",  int'(sp),  4);
        chk("call_ovf", int'(ovf), 1);
        chk("call_led", int'(led), 10);
        for (int i = 0; i < 4; i++) begin
            ret = 1'b1; step();
            chk("ret_led", int'(led), 9 - 2 * i);
        end
        chk("ret_sp", int'(sp), 0);

        // Underflow, then ret beats call
        ret = 1'b1; step();
        chk("unf_led", int'(led), 3);
        chk("unf_flag", int'(unf), 1);
        drive_bus(8'h0B); call = 1'b1; step();
        chk("call1_sp", int'(sp), 1);
        drive_bus(8'h0E); call = 1'b1; ret = 1'b1; step();
        chk("retwins_led", int'(led), 4);
        chk("retwins_sp",  int'(sp),  0);

        // c_out with call: PC kept, push still happens
        call = 1'b1; c_out = 1'b1; step();
        chk("coutcall_led", int'(led), 4);
        chk("coutcall_sp",  int'(sp),  1);
        ret = 1'b1; step();
        chk("coutcall_ret", int'(led), 5);
        c_in = 1'b1; c_out = 1'b1; step();
        chk("coutcin_led", int'(led), 5);

        // Clear at sp=2 with ovf still set
        drive_bus(8'h01); call = 1'b1; step();
        drive_bus(8'h02); call = 1'b1; step();
        chk("pre_clr_sp",  int'(sp),  2);
        chk("pre_clr_ovf", int'(ovf), 1);
        clear = 1'b1; enable = 1'b1; call = 1'b1; step();
        chk("clr_led", int'(led), 0);
        chk("clr_sp",  int'(sp),  0);
        chk("clr_ovf", int'(ovf), 0);
        chk("clr_unf", int'(unf), 0);

        // Reset pulse between edges while a call is requested
        drive_bus(8'h03); call = 1'b1; step();
        drive_bus(8'h06); call = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("arst_led", int'(led), 0);
        chk("arst_sp",  int'(sp),  0);
        model_reset();
        #1 reset_n = 1'b1;
        step();
        chk("post_rst_led", int'(led), 6);
        chk("post_rst_sp",  int'(sp),  1);

        // Bus drives zero during reset when c_out=1
        c_out = 1'b1;
        #1 reset_n = 1'b0;
        #1 chk("rst_bus_zero", int'(bus), 0);
        model_reset();
        #1 reset_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter BUS_W, default 8: shared bus width.
REQ-002 Parameter ADDR_W, default 4: program-counter width; SHALL satisfy ADDR_W <= BUS_W.
REQ-003 Parameter DEPTH, default 4: return-stack entries; SHALL be >= 1.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 bus  inout  BUS_W  shared system bus.
REQ-007 enable  input  1  increment PC.
REQ-008 c_in  input  1  unconditional jump: load PC from bus[ADDR_W-1:0].
REQ-009 c_cond  input  1  conditional jump: load from bus only when flag=1.
REQ-010 flag  input  1  branch condition qualifying c_cond.
REQ-011 call  input  1  push return address, then jump to bus target.
REQ-012 ret  input  1  pop stack top into PC.
REQ-013 c_out  input  1  drive PC onto the bus.
REQ-014 clear  input  1  synchronous clear of PC, stack and flags.
REQ-015 led  output  ADDR_W  registered PC mirror.
REQ-016 sp  output  clog2(DEPTH+1)  current stack occupancy.
REQ-017 ovf  output  1  sticky stack-overflow flag.
REQ-018 unf  output  1  sticky stack-underflow flag.

Function
REQ-019 Per cycle, exactly one action SHALL occur, in priority clear > ret > call > c_in > c_cond > enable; lower-priority requests in the same cycle SHALL be ignored.
REQ-020 clear: PC=0, sp=0, ovf=0, unf=0 at the next edge.
REQ-021 enable: PC = PC+1 modulo 2^ADDR_W; all-ones SHALL wrap to 0 with no flag.
REQ-022 c_in: PC = bus[ADDR_W-1:0]; upper bus bits SHALL be ignored.
REQ-023 c_cond: load as c_in when flag=1; when flag=0, PC SHALL hold (no increment).
REQ-024 call when sp<DEPTH: write (PC+1) mod 2^ADDR_W to entry sp, then sp+1 and PC = bus[ADDR_W-1:0], all in one edge.
REQ-025 call when sp=DEPTH: no push, PC and sp unchanged, ovf set to 1.
REQ-026 ret when sp>0: PC = entry sp-1, then sp-1, in one edge.
REQ-027 ret when sp=0: PC and sp unchanged, unf set to 1.
REQ-028 ovf and unf SHALL stay at 1 until clear or reset.
REQ-029 bus SHALL be driven with {zeros, PC} while c_out=1 and SHALL be high-impedance otherwise; the path is combinational from c_out and the current PC.
REQ-030 c_out with c_in, c_cond or call in the same cycle SHALL load the PC's own value; the net effect is PC unchanged, except that a call still pushes.
REQ-031 led SHALL equal PC after every edge (updated on the same edge as PC, no lag).
REQ-032 Latency: every action SHALL be visible on led and sp one edge after the request.

Reset
REQ-033 reset_n=0 SHALL immediately force PC=0, led=0, sp=0, ovf=0, unf=0, independent of clock.
REQ-034 Stack entry contents need not be reset; unreachable entries SHALL never be observable.
REQ-035 Reset asserted mid-call or mid-ret SHALL leave no partial push or pop; the first edge after release SHALL act on its current inputs.
REQ-036 bus SHALL be high-impedance during reset unless c_out=1, in which case it drives zero.

Structure
REQ-037 A shared package SHALL hold the action-priority encoding (enumerated NONE, CLEAR, RET, CALL, LOAD, COND, INC) and the stack-pointer width function.
REQ-038 The return stack SHALL be a sub-module, pc_return_stack: DEPTH x ADDR_W storage, push/pop/full/empty, with registered sp and flags.
REQ-039 Top level SHALL contain only priority decode, the PC register, the incrementer and the tri-state driver.

Verification (ADDR_W=4, BUS_W=8, DEPTH=4)
REQ-040 Reset, then enable for 17 cycles -> led 1..15, 0, 1; ovf=unf=0.
REQ-041 PC=5, bus=0xA7, c_in -> led=7; c_out next cycle -> bus=0x07; c_out=0 -> bus=Z.
REQ-042 PC=3, bus=0x09: c_cond with flag=0 -> led=3; with flag=1 -> led=9.
REQ-043 Five calls from PC=2 (targets 4,6,8,A,C) -> sp=4, ovf=1 after the fifth, PC=A; four rets -> PC=9,7,5,3 and sp=0.
REQ-044 ret at sp=0 -> PC held, unf=1; call with ret the same cycle at sp=1 -> ret wins.
REQ-045 reset_n pulsed low between edges during a call -> PC=0, sp=0 immediately; clear at sp=2 with ovf=1 -> all zero next edge.
